// File: rtl/gcd_iter_engine_if.sv
// Operand/result handshake bundle for the subtractive GCD engine.
// The engine takes the slave side; the operand source and result consumer take the master side.
interface gcd_iter_engine_if #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  gcd_out;
  logic [STEP_W-1:0] steps_out;
  logic              busy;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, steps_out, busy
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, steps_out, busy
  );
endinterface

// File: rtl/gcd_iter_engine.sv
// Iterative subtractive GCD engine: one compare/subtract decision per cycle,
// with both the comparison and the subtractions taken from a + ~b + 1 subtractor paths.
module gcd_iter_engine #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  gcd_iter_engine_if.slave bus
);

  if (WIDTH != 32) begin : g_width_check
    $error("gcd_iter_engine: WIDTH must be 32 to match the subtractor");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0]  ONE_W = WIDTH'(1);
  localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_q, b_q, gcd_q;
  logic [STEP_W-1:0] cnt_q, steps_q, cnt_inc;
  logic              out_valid_q;

  logic [WIDTH-1:0]  diff_ab, diff_ba;
  logic              carry_ab, a_eq_b, zero_in;
  logic              accept, sub_a, sub_b, finish, drain;

  // Two subtractor instances: A-B (with carry-out as A>=B) and B-A.
  assign {carry_ab, diff_ab} = {1'b0, a_q} + {1'b0, ~b_q} + {1'b0, ONE_W};
  assign diff_ba             = b_q + ~a_q + ONE_W;
  assign a_eq_b              = (diff_ab == '0);

  assign zero_in = (bus.a_in == '0) || (bus.b_in == '0);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE_S;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sub_a      = 1'b0;
    sub_b      = 1'b0;
    finish     = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = zero_in ? DONE : CALC;
        end
      end
      CALC: begin
        if (a_eq_b) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (carry_ab) begin
          sub_a = 1'b1;
        end else begin
          sub_b = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          drain      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      gcd_q       <= '0;
      steps_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.a_in;
        b_q   <= bus.b_in;
        cnt_q <= '0;
        if (zero_in) begin
          gcd_q   <= bus.a_in | bus.b_in;
          steps_q <= '0;
        end
      end
      if (sub_a) begin
        a_q   <= diff_ab;
        cnt_q <= cnt_inc;
      end
      if (sub_b) begin
        b_q   <= diff_ba;
        cnt_q <= cnt_inc;
      end
      if (finish) begin
        gcd_q       <= a_q;
        steps_q     <= cnt_q;
        out_valid_q <= 1'b1;
      end
      // Zero-operand results enter DONE with valid low; raise it one edge later.
      if (state == DONE) begin
        out_valid_q <= !drain;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == CALC);
  assign bus.out_valid = out_valid_q;
  assign bus.gcd_out   = gcd_q;
  assign bus.steps_out = steps_q;

endmodule

// File: tb/tb_gcd_iter_engine.sv
// Directed bench for gcd_iter_engine: vector table of hand-computed GCDs and step
// counts, plus sequences for backpressure, ignored inputs and asynchronous reset.
module tb_gcd_iter_engine;

  localparam int W      = 32;
  localparam int SW     = 32;
  localparam int BUDGET = 40;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  gcd_iter_engine_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  gcd_iter_engine #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  gcd;
    logic [SW-1:0] steps;
    int            lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for out_valid; flags any cycle before it where in_ready or busy is wrong.
  task automatic wait_valid(input bit exp_busy, output int lat, inout bit ok);
    lat = BUDGET + 1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        return;
      end
      if (bus.in_ready !== 1'b0 || bus.busy !== exp_busy) ok = 1'b0;
    end
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " in_ready after drain"}, 64'(bus.in_ready), 64'd1);
    check({name, " out_valid after drain"}, 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_gcd, input logic [SW-1:0] exp_steps,
                        input int exp_lat, input bit early);
    int lat;
    bit ok;
    bit exp_busy;
    exp_busy = (a != 0) && (b != 0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.out_ready = early;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ok = (bus.in_ready === 1'b0) && (bus.busy === exp_busy) && (bus.out_valid === 1'b0);
    wait_valid(exp_busy, lat, ok);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " gcd"}, 64'(bus.gcd_out), 64'(exp_gcd));
    check({name, " steps"}, 64'(bus.steps_out), 64'(exp_steps));
    check({name, " busy/in_ready while working"}, 64'(ok), 64'd1);
    release_result(name);
  endtask

  initial begin
    int lat;
    bit ok;
    tests = 0;
    fails = 0;

    vecs[0]  = '{a: 32'd48,         b: 32'd18,         gcd: 32'd6,          steps: 32'd4, lat: 5};
    vecs[1]  = '{a: 32'd7,          b: 32'd1,          gcd: 32'd1,          steps: 32'd6, lat: 7};
    vecs[2]  = '{a: 32'd13,         b: 32'd13,         gcd: 32'd13,         steps: 32'd0, lat: 1};
    vecs[3]  = '{a: 32'd0,          b: 32'd25,         gcd: 32'd25,         steps: 32'd0, lat: 1};
    vecs[4]  = '{a: 32'd0,          b: 32'd0,          gcd: 32'd0,          steps: 32'd0, lat: 1};
    vecs[5]  = '{a: 32'd25,         b: 32'd0,          gcd: 32'd25,         steps: 32'd0, lat: 1};
    vecs[6]  = '{a: 32'd12,         b: 32'd18,         gcd: 32'd6,          steps: 32'd2, lat: 3};
    vecs[7]  = '{a: 32'd17,         b: 32'd5,          gcd: 32'd1,          steps: 32'd6, lat: 7};
    vecs[8]  = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  gcd: 32'hFFFF_FFFF,  steps: 32'd0, lat: 1};
    vecs[9]  = '{a: 32'h8000_0000,  b: 32'h4000_0000,  gcd: 32'h4000_0000,  steps: 32'd1, lat: 2};
    vecs[10] = '{a: 32'hFFFF_FFFE,  b: 32'h7FFF_FFFF,  gcd: 32'h7FFF_FFFF,  steps: 32'd1, lat: 2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    #12;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset gcd", 64'(bus.gcd_out), 64'd0);
    check("reset steps", 64'(bus.steps_out), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].gcd, vecs[i].steps,
             vecs[i].lat, 1'b0);
    end

    // out_ready held high from the accept: must not drain before out_valid is up.
    run_op("early_ready zero", 32'd0, 32'd25, 32'd25, 32'd0, 1, 1'b1);
    run_op("early_ready equal", 32'd13, 32'd13, 32'd13, 32'd0, 1, 1'b1);

    // Backpressure: result held for 3 cycles with out_ready low.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 32'd48;
    bus.b_in     = 32'd18;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("bp latency", 64'(lat), 64'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d valid", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp hold%0d gcd", k), 64'(bus.gcd_out), 64'd6);
      check($sformatf("bp hold%0d steps", k), 64'(bus.steps_out), 64'd4);
      check($sformatf("bp hold%0d in_ready", k), 64'(bus.in_ready), 64'd0);
    end
    release_result("bp");

    // Operand and in_valid churn while calculating must be ignored.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 32'd48;
    bus.b_in     = 32'd18;
    @(posedge clk); #1;
    ok  = (bus.busy === 1'b1) && (bus.in_ready === 1'b0);
    lat = BUDGET + 1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      bus.a_in     = $urandom;
      bus.b_in     = $urandom;
      bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("churn latency", 64'(lat), 64'd5);
    check("churn gcd", 64'(bus.gcd_out), 64'd6);
    check("churn steps", 64'(bus.steps_out), 64'd4);
    check("churn busy/in_ready", 64'(ok), 64'd1);
    release_result("churn");

    // Asynchronous reset in the middle of CALC (gcd_out currently holds 6).
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 32'd100;
    bus.b_in     = 32'd75;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst calc out_valid", 64'(bus.out_valid), 64'd0);
    check("rst calc gcd", 64'(bus.gcd_out), 64'd0);
    check("rst calc steps", 64'(bus.steps_out), 64'd0);
    check("rst calc in_ready", 64'(bus.in_ready), 64'd1);
    check("rst calc busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after rst 100/75", 32'd100, 32'd75, 32'd25, 32'd3, 4, 1'b0);

    // Asynchronous reset while a result is pending in DONE.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = 32'd48;
    bus.b_in     = 32'd18;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ok = 1'b1;
    wait_valid(1'b1, lat, ok);
    check("rst done pre valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst done out_valid", 64'(bus.out_valid), 64'd0);
    check("rst done gcd", 64'(bus.gcd_out), 64'd0);
    check("rst done in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after rst 7/1", 32'd7, 32'd1, 32'd1, 32'd6, 7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcd_iter_engine.md
Name: gcd_iter_engine

Overview:
- Iterative subtractive GCD engine: accepts an operand pair (A, B) over a valid/ready handshake and repeatedly subtracts the smaller from the larger until they are equal.
- Returns gcd(A, B) and the subtraction-step count over a second valid/ready handshake.
- Drives the existing 32-bit gate-level subtractor (`substractor`: s1 = a + ~b + 1) as its sole arithmetic datapath. It is the sequencing and control end of that datapath, sitting between the operand source and the result consumer in the GCD transistor-level design.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 to match the subtractor; any other value is a lint error.
- STEP_W, 32, width of the step counter; saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  engine can accept operands; high only in IDLE.
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- gcd_out  output  WIDTH  result, unsigned.
- steps_out  output  STEP_W  number of subtractions performed.
- busy  output  1  high in CALC.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; A, B, gcd_out, steps_out, step counter = 0; out_valid = 0; busy = 0.
- in_ready is decoded from state, so it reads 1 while in reset.
- States are IDLE, CALC, DONE. in_ready = (state==IDLE); busy = (state==CALC). out_valid, gcd_out and steps_out are registered.
- IDLE: on in_valid & in_ready at a clock edge, latch A=a_in, B=b_in and clear the counter.
  - If a_in==0 or b_in==0: go directly to DONE with gcd_out = a_in | b_in (0 when both are 0) and steps_out = 0.
  - Otherwise go to CALC.
- CALC, one decision per cycle:
  - If A==B: gcd_out<=A, steps_out<=counter, out_valid<=1, go to DONE.
  - Else if A>B: A<=A-B.
  - Else: B<=B-A.
  - In both subtract cases, counter increments (saturating).
- Comparison comes from the subtractor: compute D=A-B. Carry-out of A+~B+1 = 1 means A>=B; D==0 means equal. B-A is the second subtractor instance. No other arithmetic is used.
- Latency: out_valid rises N+1 edges after the accept edge, where N = subtraction count; 1 edge for zero-operand cases.
- DONE: out_valid=1. gcd_out and steps_out are held stable until out_valid & out_ready at an edge, then out_valid<=0 and go to IDLE. No new operands are accepted before that edge; there is no same-edge accept.
- in_valid and operand changes outside IDLE are ignored.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-CALC or mid-DONE aborts immediately to reset values; a pending result is discarded.
- Worst-case runtime is gcd(x,1) with x = 2^32-1: 2^32-2 steps. The counter saturates rather than wraps; there is no timeout.

Test Plan:
- Reset, then A=48, B=18 accepted -> CALC for 5 cycles (30/18, 12/18, 12/6, 6/6, equal) -> out_valid 5 edges after accept; gcd_out=6, steps_out=4.
- A=7, B=1 -> gcd_out=1, steps_out=6, out_valid 7 edges after accept; A=B=13 -> gcd_out=13, steps_out=0, 1 edge.
- A=0, B=25 -> gcd_out=25, steps_out=0, out_valid 1 edge after accept; A=B=0 -> gcd_out=0.
- Backpressure: A=48, B=18 with out_ready low for 3 cycles after out_valid -> out_valid, gcd_out=6, steps_out=4 held stable; in_ready=0 throughout; returns to IDLE the edge after out_ready rises.
- Operands changed and in_valid toggled during CALC -> result is still gcd of the latched pair; busy=1 and in_ready=0 for the whole CALC.
- rst_n pulsed low asynchronously mid-CALC on A=100, B=75 -> out_valid=0, gcd_out=0, steps_out=0, in_ready=1 immediately; a following A=100, B=75 returns gcd_out=25, steps_out=3.
